// File: rtl/avg_fifo_rd.sv
// Moving-average stage on the read side of a show-ahead async FIFO.
// Pops whenever enabled and data is present, emits a truncated window average per accept once full.
module avg_fifo_rd #(
  parameter int D_SIZE    = 8,
  parameter int LOG2_TAPS = 2
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              enable,
  input  logic              clr,
  input  logic              r_empty,
  input  logic [D_SIZE-1:0] r_data,
  output logic              r_inc,
  output logic [D_SIZE-1:0] avg_out,
  output logic              avg_valid,
  output logic              win_full
);

  localparam int N  = 1 << LOG2_TAPS;
  localparam int CW = LOG2_TAPS + 1;
  localparam int SW = D_SIZE + LOG2_TAPS;

  localparam logic [CW-1:0]        CNT_FULL = CW'(N);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [LOG2_TAPS-1:0] IDX_ONE  = LOG2_TAPS'(1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_r;
  logic [D_SIZE-1:0]     hist_r [N];
  logic [LOG2_TAPS-1:0]  wr_idx_r;
  logic [CW-1:0]         cnt_r;
  logic [SW-1:0]         sum_r;

  logic [SW-1:0]         sum_next_s;
  logic [CW-1:0]         cnt_next_s;
  logic                  full_next_s;
  logic [D_SIZE-1:0]     avg_next_s;

  assign r_inc = enable & ~r_empty & ~clr & ~r_rst;

  // Next-state arithmetic for an accepted sample
  always_comb begin
    // Modular add/sub is exact: the final sum always fits in SW bits.
    sum_next_s = sum_r + SW'(r_data) - SW'(hist_r[wr_idx_r]);
    if (cnt_r == CNT_FULL) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
    full_next_s = (cnt_next_s == CNT_FULL);
    avg_next_s  = sum_next_s[SW-1:LOG2_TAPS];
  end

  // Window history, running sum, fill FSM and registered outputs
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      for (int i = 0; i < N; i++) begin
        hist_r[i] <= '0;
      end
      wr_idx_r  <= '0;
      cnt_r     <= '0;
      sum_r     <= '0;
      state_r   <= FILL;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      win_full  <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < N; i++) begin
        hist_r[i] <= '0;
      end
      wr_idx_r  <= '0;
      cnt_r     <= '0;
      sum_r     <= '0;
      state_r   <= FILL;
      avg_valid <= 1'b0;
      win_full  <= 1'b0;
    end else if (r_inc) begin
      hist_r[wr_idx_r] <= r_data;
      wr_idx_r         <= wr_idx_r + IDX_ONE;
      cnt_r            <= cnt_next_s;
      sum_r            <= sum_next_s;
      win_full         <= full_next_s;
      avg_valid        <= full_next_s;
      if (full_next_s) begin
        avg_out <= avg_next_s;
      end
      case (state_r)
        FILL:    state_r <= full_next_s ? RUN : FILL;
        RUN:     state_r <= RUN;
        default: state_r <= FILL;
      endcase
    end else begin
      avg_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avg_fifo_rd.sv
// Directed bench for avg_fifo_rd (N=4) with a queue-based window model checked every cycle.
module tb_avg_fifo_rd;

  localparam int D_SIZE    = 8;
  localparam int LOG2_TAPS = 2;
  localparam int N         = 4;

  logic              r_clk = 1'b0;
  logic              r_rst = 1'b1;
  logic              enable = 1'b0;
  logic              clr = 1'b0;
  logic              r_empty = 1'b1;
  logic [D_SIZE-1:0] r_data = '0;
  logic              r_inc;
  logic [D_SIZE-1:0] avg_out;
  logic              avg_valid;
  logic              win_full;

  int ncmp = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  int q[$];
  int m_avg = 0;
  bit m_valid = 1'b0;
  bit m_full = 1'b0;
  int got[$];

  avg_fifo_rd #(.D_SIZE(D_SIZE), .LOG2_TAPS(LOG2_TAPS)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .enable(enable), .clr(clr),
    .r_empty(r_empty), .r_data(r_data), .r_inc(r_inc),
    .avg_out(avg_out), .avg_valid(avg_valid), .win_full(win_full)
  );

  always #5 r_clk = ~r_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_sum();
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  // Apply one cycle of inputs, then advance the window model by the same rules.
  task automatic tick(input bit en, input bit emp, input bit cl, input bit rs, input int d);
    bit acc;
    enable  = en;
    r_empty = emp;
    clr     = cl;
    r_rst   = rs;
    r_data  = D_SIZE'(d);
    @(posedge r_clk);
    #1;
    acc = en & ~emp & ~cl & ~rs;
    if (rs) begin
      q.delete();
      m_avg = 0; m_valid = 1'b0; m_full = 1'b0;
    end else if (cl) begin
      q.delete();
      m_valid = 1'b0; m_full = 1'b0;
    end else if (acc) begin
      q.push_back(d);
      if (q.size() > N) void'(q.pop_front());
      m_full = (q.size() == N);
      m_valid = m_full;
      if (m_full) m_avg = model_sum() / N;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic pop(input int d);
    tick(1'b1, 1'b0, 1'b0, 1'b0, d);
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge r_clk) begin
    if (chk_on) begin
      check("r_inc", {31'd0, r_inc}, {31'd0, enable & ~r_empty & ~clr & ~r_rst});
      check("avg_valid", {31'd0, avg_valid}, {31'd0, m_valid});
      check("win_full", {31'd0, win_full}, {31'd0, m_full});
      check("avg_out", {24'd0, avg_out}, m_avg);
    end
  end

  initial begin
    // Reset with data present and enabled: no pops allowed
    tick(1'b1, 1'b0, 1'b0, 1'b1, 99);
    chk_on = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b1, 99);
    check("rst_avg", {24'd0, avg_out}, 32'd0);
    check("rst_valid", {31'd0, avg_valid}, 32'd0);
    check("rst_full", {31'd0, win_full}, 32'd0);

    // Fill and slide
    pop(10); pop(20); pop(30);
    check("fill_novalid", {31'd0, avg_valid}, 32'd0);
    pop(40);
    check("fill_valid", {31'd0, avg_valid}, 32'd1);
    check("fill_avg", {24'd0, avg_out}, 32'd25);
    check("fill_full", {31'd0, win_full}, 32'd1);
    pop(50);
    check("slide_avg50", {24'd0, avg_out}, 32'd35);
    pop(60);
    check("slide_avg60", {24'd0, avg_out}, 32'd45);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("idle_valid", {31'd0, avg_valid}, 32'd0);
    check("idle_hold", {24'd0, avg_out}, 32'd45);

    // Truncation and saturation
    tick(1'b1, 1'b0, 1'b1, 1'b0, 7);
    pop(1); pop(1); pop(1); pop(2);
    check("trunc_avg", {24'd0, avg_out}, 32'd1);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 7);
    check("clr_hold_avg", {24'd0, avg_out}, 32'd1);
    pop(255); pop(255); pop(255); pop(255);
    check("sat_avg", {24'd0, avg_out}, 32'd255);
    check("sat_model_sum", model_sum(), 32'd1020);

    // Flow control: empty every other cycle, enable low for 3 cycles
    tick(1'b1, 1'b0, 1'b1, 1'b0, 0);
    got.delete();
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, 0);
      if (i == 3) begin
        for (int j = 0; j < 3; j++) tick(1'b0, 1'b0, 1'b0, 1'b0, 10 * (i + 1));
      end
      tick(1'b1, 1'b0, 1'b0, 1'b0, 10 * (i + 1));
      if (avg_valid) got.push_back(int'(avg_out));
    end
    check("flow_count", got.size(), 32'd4);
    if (got.size() == 4) begin
      check("flow_avg0", got[0], 32'd25);
      check("flow_avg1", got[1], 32'd35);
      check("flow_avg2", got[2], 32'd45);
      check("flow_avg3", got[3], 32'd55);
    end

    // Flush mid-window with data waiting
    tick(1'b1, 1'b0, 1'b1, 1'b0, 0);
    pop(5); pop(6);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 100);
    check("flush_full", {31'd0, win_full}, 32'd0);
    pop(100); pop(100); pop(100);
    check("flush_novalid", {31'd0, avg_valid}, 32'd0);
    pop(104);
    check("flush_avg", {24'd0, avg_out}, 32'd101);

    // Reset during RUN with continuous data
    pop(8); pop(8); pop(8); pop(8);
    check("run_avg8", {24'd0, avg_out}, 32'd8);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8);
    check("mrst_avg", {24'd0, avg_out}, 32'd0);
    check("mrst_full", {31'd0, win_full}, 32'd0);
    pop(40); pop(40); pop(40);
    check("mrst_novalid", {31'd0, avg_valid}, 32'd0);
    pop(41);
    check("mrst_valid", {31'd0, avg_valid}, 32'd1);
    check("mrst_avg_first", {24'd0, avg_out}, 32'd40);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/avg_fifo_rd.md
# avg_fifo_rd

Moving-average stage directly downstream of the DSP block's asynchronous FIFO, running entirely in the read clock domain. It pops samples from the FIFO read side whenever data is available and enabled. It keeps a circular history of the last 2^LOG2_TAPS samples and a running sum. It emits one truncated average per accepted sample once the window has filled.

## Interface
- D_SIZE, 8: sample width, unsigned; equals the FIFO data width.
- LOG2_TAPS, 2: log2 of window length; N = 2^LOG2_TAPS. Legal range is 1..5.

- r_clk  input  1  read-domain clock. This is the only clock.
- r_rst  input  1  reset, synchronous and active-high.
- enable  input  1  allows FIFO pops. When low, the block holds all state.
- clr  input  1  synchronous flush of the window, single-cycle pulse.
- r_empty  input  1  FIFO empty flag, already synchronous to r_clk.
- r_data  input  D_SIZE  FIFO read data, show-ahead: valid whenever r_empty=0.
- r_inc  output  1  FIFO pop strobe, combinational.
- avg_out  output  D_SIZE  registered window average.
- avg_valid  output  1  one-cycle strobe qualifying avg_out.
- win_full  output  1  high once N samples are held since the last reset or clr.

## Operation
- Pop rule: r_inc = enable & ~r_empty & ~clr & ~r_rst.
  - A sample is "accepted" in every cycle where r_inc=1.
  - r_inc is never high while r_empty=1, so the block never underflows the FIFO.
- State:
  - hist[0..N-1], D_SIZE bits each.
  - wr_idx, LOG2_TAPS bits, wraps N-1 -> 0.
  - cnt, LOG2_TAPS+1 bits, saturates at N.
  - sum, D_SIZE+LOG2_TAPS bits.
- FSM with two states:
  - FILL (reset state): while cnt < N.
  - RUN: once cnt reaches N.
  - FILL -> RUN on the accept that makes cnt = N.
  - RUN -> FILL only on clr or r_rst.
- On accept:
  - sum_next = sum + r_data - hist[wr_idx].
  - hist[wr_idx] <= r_data.
  - wr_idx <= wr_idx + 1, mod N.
  - cnt <= min(cnt+1, N).
  - sum <= sum_next.
- Arithmetic:
  - Subtraction is exact because hist is zero-filled on reset/clr. During FILL the subtracted term is therefore 0.
  - sum never exceeds N*(2^D_SIZE - 1), so there is no overflow. Width is fixed at D_SIZE+LOG2_TAPS.
- Output:
  - On an accept that leaves cnt = N (the filling accept and every accept in RUN): avg_out <= sum_next >> LOG2_TAPS (truncation, no rounding) and avg_valid <= 1.
  - Otherwise avg_valid <= 0 and avg_out holds its value.
- win_full is registered and equals (cnt == N).
- clr:
  - Zeroes hist, sum, wr_idx, cnt, win_full and avg_valid, and returns the FSM to FILL.
  - avg_out holds its last value.
  - No pop occurs in a clr cycle.
- enable=0 or r_empty=1: no accept; all state holds; avg_valid=0.

## Timing
- Reset: on a r_clk edge with r_rst=1, the following are all 0 and the FSM is in FILL:
  - avg_out, avg_valid, win_full;
  - hist, sum, wr_idx, cnt.
  - r_inc is forced to 0 for the whole cycle r_rst is high.
- Reset or clr mid-window discards partial data. The next avg_valid requires N fresh accepts.
- Latency: a sample accepted in cycle k updates avg_out and asserts avg_valid in cycle k+1.
- Throughput: one accept per cycle. avg_valid can stay high on consecutive cycles during back-to-back pops.
- The first avg_valid after reset/clr appears one cycle after the N-th accept.
- Simultaneous events:
  - r_rst overrides everything.
  - clr overrides an accept. The FIFO word is not popped and remains at the FIFO head.
- Downstream must capture avg_out when avg_valid=1. There is no backpressure into this block.

## Test plan
- Reset: assert r_rst 2 cycles while r_empty=0 and enable=1 -> r_inc=0 throughout; all outputs 0 after release.
- Fill and slide (N=4): pop 10,20,30,40 back-to-back -> avg_valid only in the cycle after 40, avg_out=25, win_full=1; then pop 50 -> avg_out=35; then pop 60 -> avg_out=45.
- Truncation and saturation: pop 1,1,1,2 -> avg_out=1. After clr, pop 255 x4 -> avg_out=255, with internal sum=1020 and no wrap.
- Flow control: r_empty toggles every other cycle and enable drops for 3 cycles mid-stream -> r_inc is never high with r_empty=1 or enable=0; outputs hold; the average sequence matches the gap-free run.
- Flush: clr after 2 of 4 samples, asserted in a cycle with r_empty=0 -> r_inc=0 in that cycle, win_full=0, no avg_valid until 4 further accepts; the first average uses only post-clr samples.
- Mid-run reset: r_rst during RUN with continuous data -> the same behaviour as clr plus avg_out=0; the first valid output appears one cycle after the 4th post-reset accept.
